// File: rtl/wb_stage_if.sv
// Writeback stage bus: retire handshake, data-memory return and
// register-bank write port grouped for the wb_stage boundary.
interface wb_stage_if #(
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  valid_i;
   logic                  ready_o;
   logic [ADDR_WIDTH-1:0] rd_addr_i;
   logic [WORD_WIDTH-1:0] alu_result_i;
   logic                  write_en_i;
   logic                  load_ctrl_i;
   logic [2:0]            load_type_i;
   logic [1:0]            mem_addr_lsb_i;
   logic                  dmem_rvalid_i;
   logic [WORD_WIDTH-1:0] dmem_rdata_i;
   logic [ADDR_WIDTH-1:0] reg_waddr_o;
   logic [WORD_WIDTH-1:0] reg_wdata_o;
   logic                  reg_wen_o;
   logic                  stall_o;
   logic                  load_err_o;

   modport slave (
      input  valid_i, rd_addr_i, alu_result_i,
      input  write_en_i, load_ctrl_i,
      input  load_type_i, mem_addr_lsb_i,
      input  dmem_rvalid_i, dmem_rdata_i,
      output ready_o, reg_waddr_o, reg_wdata_o,
      output reg_wen_o, stall_o, load_err_o
   );

   modport master (
      output valid_i, rd_addr_i, alu_result_i,
      output write_en_i, load_ctrl_i,
      output load_type_i, mem_addr_lsb_i,
      output dmem_rvalid_i, dmem_rdata_i,
      input  ready_o, reg_waddr_o, reg_wdata_o,
      input  reg_wen_o, stall_o, load_err_o
   );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results directly, waits for load data,
// extends it and drives the register-bank write port.
module wb_stage #(
   parameter int WORD_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int LOAD_TIMEOUT = 15
) (
   input logic       clk,
   input logic       rst_n,
   wb_stage_if.slave bus
);
   localparam int CW = $clog2(LOAD_TIMEOUT + 1);

   typedef enum logic {
      IDLE,
      WAIT_LOAD
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] rd_q, rd_d;
   logic [2:0]            type_q, type_d;
   logic [1:0]            lsb_q, lsb_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
   logic                  wen_q, wen_d;
   logic                  err_q, err_d;

   logic                  legal;
   logic                  misaligned;
   logic [7:0]            byte_v;
   logic [15:0]           half_v;
   logic [WORD_WIDTH-1:0] ext;

   always_comb begin
      legal      = 1'b0;
      misaligned = 1'b0;
      case (bus.load_type_i)
         3'b000, 3'b100: legal = 1'b1;
         3'b001, 3'b101: begin
            legal      = 1'b1;
            misaligned = (bus.mem_addr_lsb_i == 2'b11);
         end
         3'b010: begin
            legal      = 1'b1;
            misaligned = (bus.mem_addr_lsb_i != 2'b00);
         end
         default: legal = 1'b0;
      endcase
   end

   // Memory returns an aligned word; pick the lane from the captured offset
   always_comb begin
      byte_v = bus.dmem_rdata_i[{lsb_q, 3'b000} +: 8];
      half_v = bus.dmem_rdata_i[{lsb_q[1], 4'b0000} +: 16];
      case (type_q)
         3'b000:  ext = {{(WORD_WIDTH-8){byte_v[7]}}, byte_v};
         3'b100:  ext = {{(WORD_WIDTH-8){1'b0}}, byte_v};
         3'b001:  ext = {{(WORD_WIDTH-16){half_v[15]}}, half_v};
         3'b101:  ext = {{(WORD_WIDTH-16){1'b0}}, half_v};
         default: ext = bus.dmem_rdata_i;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      type_d  = type_q;
      lsb_d   = lsb_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      wen_d   = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.valid_i && bus.load_ctrl_i) begin
               if (!legal || misaligned) begin
                  err_d = 1'b1;
               end else begin
                  rd_d    = bus.rd_addr_i;
                  type_d  = bus.load_type_i;
                  lsb_d   = bus.mem_addr_lsb_i;
                  cnt_d   = '0;
                  state_d = WAIT_LOAD;
               end
            end else if (bus.valid_i && bus.write_en_i) begin
               wen_d   = (bus.rd_addr_i != '0);
               waddr_d = bus.rd_addr_i;
               wdata_d = bus.alu_result_i;
            end
         end
         WAIT_LOAD: begin
            if (bus.dmem_rvalid_i) begin
               wen_d   = (rd_q != '0);
               waddr_d = rd_q;
               wdata_d = ext;
               state_d = IDLE;
            end else if (cnt_q == CW'(LOAD_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rd_q    <= '0;
         type_q  <= '0;
         lsb_q   <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         wen_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         type_q  <= type_d;
         lsb_q   <= lsb_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         wen_q   <= wen_d;
         err_q   <= err_d;
      end
   end

   assign bus.ready_o     = (state_q == IDLE);
   assign bus.stall_o     = (state_q == WAIT_LOAD);
   assign bus.reg_waddr_o = waddr_q;
   assign bus.reg_wdata_o = wdata_q;
   assign bus.reg_wen_o   = wen_q;
   assign bus.load_err_o  = err_q;
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: vector table plus scoreboard,
// with hand sequences for back-to-back, hold and mid-load reset.
module tb_wb_stage;
   localparam int TO = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb_stage_if bus ();

   wb_stage #(
      .WORD_WIDTH  (32),
      .ADDR_WIDTH  (5),
      .LOAD_TIMEOUT(TO)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic        ld;
      logic [2:0]  lt;
      logic [1:0]  lsb;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] alu;
      logic [31:0] rdata;
      int          dly;
      logic        e_wen;
      logic [31:0] e_wdata;
      logic        e_err;
   } vec_t;

   typedef struct {
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        err;
   } exp_t;

   exp_t sbq[$];
   vec_t vt[$];
   int checks = 0;
   int errors = 0;
   int wen_seen = 0;
   int wen_exp = 0;

   always @(negedge clk) if (bus.reg_wen_o === 1'b1) wen_seen++;

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in;
      bus.valid_i        = 1'b0;
      bus.rd_addr_i      = '0;
      bus.alu_result_i   = '0;
      bus.write_en_i     = 1'b0;
      bus.load_ctrl_i    = 1'b0;
      bus.load_type_i    = '0;
      bus.mem_addr_lsb_i = '0;
      bus.dmem_rvalid_i  = 1'b0;
      bus.dmem_rdata_i   = '0;
   endtask

   task automatic push(logic wen, logic [4:0] a, logic [31:0] d, logic err);
      exp_t e;
      e.wen = wen;
      e.waddr = a;
      e.wdata = d;
      e.err = err;
      sbq.push_back(e);
      if (wen) wen_exp++;
   endtask

   task automatic expect_out(string n);
      exp_t e;
      if (sbq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty, got wen=%0b", n, bus.reg_wen_o);
         return;
      end
      e = sbq.pop_front();
      chk({n, " wen"}, 32'(bus.reg_wen_o), 32'(e.wen));
      chk({n, " err"}, 32'(bus.load_err_o), 32'(e.err));
      if (e.wen) begin
         chk({n, " waddr"}, 32'(bus.reg_waddr_o), 32'(e.waddr));
         chk({n, " wdata"}, bus.reg_wdata_o, e.wdata);
      end
   endtask

   function automatic vec_t mk(logic ld, logic [2:0] lt, logic [1:0] lsb,
                               logic [4:0] rd, logic we, logic [31:0] alu,
                               logic [31:0] rdata, int dly, logic e_wen,
                               logic [31:0] e_wdata, logic e_err);
      vec_t v;
      v.ld = ld; v.lt = lt; v.lsb = lsb; v.rd = rd; v.we = we;
      v.alu = alu; v.rdata = rdata; v.dly = dly;
      v.e_wen = e_wen; v.e_wdata = e_wdata; v.e_err = e_err;
      return v;
   endfunction

   task automatic run(int idx, vec_t v);
      string n;
      n = $sformatf("vec%0d", idx);
      bus.valid_i        = 1'b1;
      bus.rd_addr_i      = v.rd;
      bus.alu_result_i   = v.alu;
      bus.write_en_i     = v.we;
      bus.load_ctrl_i    = v.ld;
      bus.load_type_i    = v.lt;
      bus.mem_addr_lsb_i = v.lsb;
      push(v.e_wen, v.rd, v.e_wdata, v.e_err);
      cyc;
      idle_in;
      if (v.ld && v.dly > 0) begin
         for (int i = 1; i <= TO; i++) begin
            chk({n, " stall"}, 32'(bus.stall_o), 32'd1);
            bus.dmem_rvalid_i = (i == v.dly);
            bus.dmem_rdata_i  = v.rdata;
            cyc;
            if (i == v.dly) break;
         end
         bus.dmem_rvalid_i = 1'b0;
      end
      expect_out(n);
      chk({n, " ready"}, 32'(bus.ready_o), 32'd1);
      chk({n, " stall_end"}, 32'(bus.stall_o), 32'd0);
      cyc;
      chk({n, " wen_pulse"}, 32'(bus.reg_wen_o), 32'd0);
      chk({n, " err_pulse"}, 32'(bus.load_err_o), 32'd0);
   endtask

   initial begin
      idle_in;
      // ld lt lsb rd we alu rdata dly | wen wdata err
      vt.push_back(mk(0, 3'b000, 2'd0, 5'd5, 1, 32'h1234_5678, 0, 0, 1, 32'h1234_5678, 0));
      vt.push_back(mk(1, 3'b000, 2'd2, 5'd3, 0, 0, 32'h0080_0000, 3, 1, 32'hFFFF_FF80, 0));
      vt.push_back(mk(1, 3'b101, 2'd2, 5'd4, 0, 0, 32'h8001_0000, 1, 1, 32'h0000_8001, 0));
      vt.push_back(mk(1, 3'b010, 2'd1, 5'd6, 0, 0, 0, 0, 0, 0, 1));
      vt.push_back(mk(1, 3'b011, 2'd0, 5'd6, 0, 0, 0, 0, 0, 0, 1));
      vt.push_back(mk(1, 3'b010, 2'd0, 5'd7, 0, 0, 32'h1111_1111, 99, 0, 0, 1));
      vt.push_back(mk(1, 3'b010, 2'd0, 5'd7, 0, 0, 32'hCAFE_BABE, 15, 1, 32'hCAFE_BABE, 0));
      vt.push_back(mk(0, 3'b000, 2'd0, 5'd0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0));
      vt.push_back(mk(1, 3'b100, 2'd3, 5'd8, 0, 0, 32'h9A00_0000, 2, 1, 32'h0000_009A, 0));
      vt.push_back(mk(1, 3'b001, 2'd0, 5'd9, 0, 0, 32'h1234_F00D, 1, 1, 32'hFFFF_F00D, 0));
      vt.push_back(mk(1, 3'b001, 2'd1, 5'd10, 0, 0, 32'h8000_7FFF, 1, 1, 32'h0000_7FFF, 0));
      vt.push_back(mk(1, 3'b001, 2'd3, 5'd10, 0, 0, 0, 0, 0, 0, 1));
      vt.push_back(mk(1, 3'b000, 2'd1, 5'd11, 0, 0, 32'h0000_7F00, 4, 1, 32'h0000_007F, 0));
      vt.push_back(mk(0, 3'b000, 2'd0, 5'd12, 0, 32'h5555_AAAA, 0, 0, 0, 0, 0));
      vt.push_back(mk(1, 3'b110, 2'd0, 5'd13, 0, 0, 0, 0, 0, 0, 1));
      vt.push_back(mk(1, 3'b111, 2'd0, 5'd13, 0, 0, 0, 0, 0, 0, 1));
      vt.push_back(mk(1, 3'b010, 2'd0, 5'd0, 0, 0, 32'h7777_7777, 2, 0, 0, 0));
      vt.push_back(mk(1, 3'b010, 2'd0, 5'd31, 0, 0, 32'h8000_0000, 1, 1, 32'h8000_0000, 0));
      vt.push_back(mk(1, 3'b101, 2'd1, 5'd14, 0, 0, 32'h0000_FFFE, 2, 1, 32'h0000_FFFE, 0));

      #12;
      chk("rst wen", 32'(bus.reg_wen_o), 32'd0);
      chk("rst waddr", 32'(bus.reg_waddr_o), 32'd0);
      chk("rst wdata", bus.reg_wdata_o, 32'd0);
      chk("rst err", 32'(bus.load_err_o), 32'd0);
      chk("rst stall", 32'(bus.stall_o), 32'd0);
      chk("rst ready", 32'(bus.ready_o), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      cyc;

      foreach (vt[i]) run(i, vt[i]);

      // back-to-back ALU retirements
      bus.valid_i = 1'b1;
      bus.write_en_i = 1'b1;
      bus.rd_addr_i = 5'd1;
      bus.alu_result_i = 32'hA5A5_0001;
      push(1, 5'd1, 32'hA5A5_0001, 0);
      cyc;
      expect_out("b2b0");
      bus.rd_addr_i = 5'd2;
      bus.alu_result_i = 32'h5A5A_0002;
      push(1, 5'd2, 32'h5A5A_0002, 0);
      cyc;
      expect_out("b2b1");
      idle_in;
      bus.dmem_rvalid_i = 1'b1;
      cyc;
      chk("hold wen", 32'(bus.reg_wen_o), 32'd0);
      chk("hold waddr", 32'(bus.reg_waddr_o), 32'd2);
      chk("hold wdata", bus.reg_wdata_o, 32'h5A5A_0002);
      chk("idle rvalid stall", 32'(bus.stall_o), 32'd0);
      bus.dmem_rvalid_i = 1'b0;
      cyc;

      // reset while waiting for load data
      bus.valid_i = 1'b1;
      bus.load_ctrl_i = 1'b1;
      bus.load_type_i = 3'b010;
      bus.rd_addr_i = 5'd20;
      cyc;
      idle_in;
      cyc;
      chk("rstw stall", 32'(bus.stall_o), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstw ready", 32'(bus.ready_o), 32'd1);
      chk("rstw stall0", 32'(bus.stall_o), 32'd0);
      chk("rstw wdata", bus.reg_wdata_o, 32'd0);
      chk("rstw waddr", 32'(bus.reg_waddr_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.dmem_rvalid_i = 1'b1;
      bus.dmem_rdata_i = 32'hFFFF_FFFF;
      cyc;
      bus.dmem_rvalid_i = 1'b0;
      chk("late rvalid wen", 32'(bus.reg_wen_o), 32'd0);
      chk("late rvalid wdata", bus.reg_wdata_o, 32'd0);
      chk("late rvalid err", 32'(bus.load_err_o), 32'd0);
      cyc;
      chk("late rvalid wen2", 32'(bus.reg_wen_o), 32'd0);
      cyc;

      chk("wen pulse count", 32'(wen_seen), 32'(wen_exp));
      chk("scoreboard drained", 32'(sbq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
